// File: rtl/fpnew_opgroup_issue_arb.sv
// -----------------------------------------------------------------------------
// fpnew_opgroup_issue_arb
//
// Shares one FPU operation-group block between NumReq independent requesters.
// Incoming operations are round-robin arbitrated onto the block's input
// handshake and tagged with the requester ID. An outstanding-operation counter
// limits the number of operations in flight. Each returning result is routed
// back to its owner by tag.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             synchronous flush of all in-flight tracking
//   req_valid_i         per-requester operation valid
//   req_ready_o         per-requester operation accepted (one-hot or zero)
//   req_payload_i       per-requester operation bundle
//   unit_valid_o        operation valid towards the opgroup block
//   unit_ready_i        opgroup block ready to accept an operation
//   unit_payload_o      granted operation bundle
//   unit_tag_o          granted requester ID
//   unit_flush_o        flush forwarded to the opgroup block
//   unit_res_valid_i    result valid from the opgroup block
//   unit_res_ready_o    result ready towards the opgroup block
//   unit_res_tag_i      requester ID carried by the result
//   unit_res_i          result bundle
//   rsp_valid_o         per-requester result valid
//   rsp_ready_i         per-requester result ready
//   rsp_result_o        result bundle broadcast to all requesters
//   tag_err_o           one-cycle pulse after a result with an unknown tag
//   busy_o              operations in flight or an issue being offered
// -----------------------------------------------------------------------------
module fpnew_opgroup_issue_arb #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned PayloadWidth   = 128,
  parameter int unsigned ResultWidth    = 38,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdWidth        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  input  logic [NumReq-1:0][PayloadWidth-1:0]   req_payload_i,
  output logic                                  unit_valid_o,
  input  logic                                  unit_ready_i,
  output logic [PayloadWidth-1:0]               unit_payload_o,
  output logic [IdWidth-1:0]                    unit_tag_o,
  output logic                                  unit_flush_o,
  input  logic                                  unit_res_valid_i,
  output logic                                  unit_res_ready_o,
  input  logic [IdWidth-1:0]                    unit_res_tag_i,
  input  logic [ResultWidth-1:0]                unit_res_i,
  output logic [NumReq-1:0]                     rsp_valid_o,
  input  logic [NumReq-1:0]                     rsp_ready_i,
  output logic [ResultWidth-1:0]                rsp_result_o,
  output logic                                  tag_err_o,
  output logic                                  busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  // One extra bit so pointer sums and the requester count fit without wrap.
  localparam logic [IdWidth:0]    NumReqW = (IdWidth + 1)'(NumReq);
  localparam logic [CntWidth-1:0] MaxOutW = CntWidth'(MaxOutstanding);

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  lock_state_e          state_q, state_d;
  logic [IdWidth-1:0]   lock_id_q, lock_id_d;
  logic [IdWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 tag_err_q, tag_err_d;

  logic [IdWidth-1:0]   rr_grant;
  logic                 rr_found;
  logic [IdWidth:0]     rr_idx;
  logic [IdWidth-1:0]   grant;
  logic                 any_valid;
  logic                 can_issue;
  logic                 issue_valid;
  logic                 issue_hs;
  logic                 res_hs;
  logic                 retire;
  logic                 tag_ok;
  logic                 res_ready;
  logic [NumReq-1:0]    rsp_valid;
  logic [NumReq-1:0]    req_ready;
  logic [IdWidth:0]     ptr_next;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      rr_idx = {1'b0, rr_ptr_q} + (IdWidth + 1)'(off);
      if (rr_idx >= NumReqW) begin
        rr_idx = rr_idx - NumReqW;
      end else begin
        rr_idx = rr_idx;
      end
      if (!rr_found && req_valid_i[rr_idx[IdWidth-1:0]]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx[IdWidth-1:0];
      end else begin
        rr_found = rr_found;
      end
    end
  end

  // A held (un-accepted) offer keeps its requester so payload/tag stay stable.
  assign grant     = (state_q == LOCKED) ? lock_id_q : rr_grant;
  assign any_valid = |req_valid_i;

  // Result demux; tags outside the requester range are sunk unconditionally.
  always_comb begin
    tag_ok    = 1'b0;
    rsp_valid = '0;
    res_ready = 1'b1;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (unit_res_tag_i == IdWidth'(i)) begin
        tag_ok       = 1'b1;
        rsp_valid[i] = unit_res_valid_i;
        res_ready    = rsp_ready_i[i];
      end else begin
        tag_ok = tag_ok;
      end
    end
  end

  assign res_hs = unit_res_valid_i & res_ready;
  // A result arriving with nothing outstanding does not count as a retire.
  assign retire = res_hs & (cnt_q != '0);

  // A retire in the same cycle frees a slot, so a full counter can still issue.
  assign can_issue   = (cnt_q < MaxOutW) | res_hs;
  assign issue_valid = any_valid & can_issue & ~flush_i;
  assign issue_hs    = issue_valid & unit_ready_i;

  // Accept strobe only towards the granted requester.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (issue_hs && (grant == IdWidth'(i))) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Grant-lock FSM: hold the grant while an offer waits for unit_ready_i.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    if (flush_i) begin
      state_d = FREE;
    end else begin
      case (state_q)
        FREE: begin
          if (issue_valid && !unit_ready_i) begin
            state_d   = LOCKED;
            lock_id_d = grant;
          end else begin
            state_d = FREE;
          end
        end
        LOCKED: begin
          if (unit_ready_i) begin
            state_d = FREE;
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d = FREE;
        end
      endcase
    end
  end

  // Pointer moves past the requester that just issued.
  always_comb begin
    ptr_next = {1'b0, grant} + (IdWidth + 1)'(1);
    rr_ptr_d = rr_ptr_q;
    if (issue_hs) begin
      if (ptr_next >= NumReqW) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = ptr_next[IdWidth-1:0];
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Outstanding counter; flush wins over any same-cycle issue/retire.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (issue_hs && !retire) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!issue_hs && retire) begin
      cnt_d = cnt_q - CntWidth'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Tag-error pulse is raised the cycle after an unknown tag is sunk.
  always_comb begin
    if (flush_i) begin
      tag_err_d = 1'b0;
    end else begin
      tag_err_d = res_hs & ~tag_ok;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FREE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      tag_err_q <= tag_err_d;
    end
  end

  assign unit_valid_o     = issue_valid;
  assign unit_payload_o   = req_payload_i[grant];
  assign unit_tag_o       = grant;
  assign unit_flush_o     = flush_i;
  assign req_ready_o      = req_ready;
  assign unit_res_ready_o = res_ready;
  assign rsp_valid_o      = rsp_valid;
  assign rsp_result_o     = unit_res_i;
  assign tag_err_o        = tag_err_q;
  assign busy_o           = (cnt_q != '0) | issue_valid;

endmodule

// File: tb/tb_fpnew_opgroup_issue_arb.sv
module tb_fpnew_opgroup_issue_arb;

  localparam int NR = 3;
  localparam int PW = 16;
  localparam int RW = 8;
  localparam int MO = 4;
  localparam int IW = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flush;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0]            req_ready;
  logic [NR-1:0][PW-1:0]    req_payload;
  logic                     unit_valid;
  logic                     unit_ready;
  logic [PW-1:0]            unit_payload;
  logic [IW-1:0]            unit_tag;
  logic                     unit_flush;
  logic                     res_valid;
  logic                     res_ready;
  logic [IW-1:0]            res_tag;
  logic [RW-1:0]            res;
  logic [NR-1:0]            rsp_valid;
  logic [NR-1:0]            rsp_ready;
  logic [RW-1:0]            rsp_result;
  logic                     tag_err;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_tag_q[$];

  fpnew_opgroup_issue_arb #(
    .NumReq(NR), .PayloadWidth(PW), .ResultWidth(RW), .MaxOutstanding(MO), .IdWidth(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_payload_i(req_payload),
    .unit_valid_o(unit_valid), .unit_ready_i(unit_ready), .unit_payload_o(unit_payload),
    .unit_tag_o(unit_tag), .unit_flush_o(unit_flush),
    .unit_res_valid_i(res_valid), .unit_res_ready_o(res_ready),
    .unit_res_tag_i(res_tag), .unit_res_i(res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .tag_err_o(tag_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush      = 1'b0;
    req_valid  = '0;
    unit_ready = 1'b0;
    res_valid  = 1'b0;
    res_tag    = '0;
    res        = '0;
    rsp_ready  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issues one operation per cycle for n cycles, expecting each to be offered.
  task automatic issue_n(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      #1;
      checks++;
      if (unit_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s[%0d]: unit_valid got %b expected 1", name, k, unit_valid);
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    checks++;
    if ({unit_valid, req_ready, rsp_valid, res_ready, tag_err, busy, unit_flush} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b rr=%b rsp=%b rdy=%b te=%b busy=%b expected all 0",
               unit_valid, req_ready, rsp_valid, res_ready, tag_err, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({unit_valid, busy, tag_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got v=%b busy=%b te=%b expected 000", unit_valid, busy, tag_err);
    end
  endtask

  task automatic test_round_robin();
    logic [IW-1:0] e;
    logic [NR-1:0] exp_rdy;
    do_reset();
    for (int k = 0; k < 6; k++) exp_tag_q.push_back(IW'(k % 2));
    exp_tag_q.push_back(2'd2);
    exp_tag_q.push_back(2'd0);
    exp_tag_q.push_back(2'd1);
    exp_tag_q.push_back(2'd2);
    req_valid  = 3'b011;
    unit_ready = 1'b1;
    res_valid  = 1'b1;
    res_tag    = 2'd0;
    res        = 8'h5A;
    rsp_ready  = 3'b111;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) req_valid = 3'b111;
      #1;
      if (unit_valid && unit_ready && exp_tag_q.size() != 0) begin
        e = exp_tag_q.pop_front();
        exp_rdy = NR'(1) << e;
        checks++;
        if (unit_tag !== e) begin
          errors++;
          $display("FAIL rr_tag[%0d]: got %0d expected %0d", c, unit_tag, e);
        end
        checks++;
        if (unit_payload !== req_payload[e]) begin
          errors++;
          $display("FAIL rr_payload[%0d]: got %h expected %h", c, unit_payload, req_payload[e]);
        end
        checks++;
        if (req_ready !== exp_rdy) begin
          errors++;
          $display("FAIL rr_req_ready[%0d]: got %b expected %b", c, req_ready, exp_rdy);
        end
      end else begin
        checks++;
        errors++;
        $display("FAIL rr_no_issue[%0d]: unit_valid got %b expected 1", c, unit_valid);
      end
      if (c == 3) begin
        checks++;
        if (rsp_valid !== 3'b001 || rsp_result !== 8'h5A) begin
          errors++;
          $display("FAIL rr_rsp: got valid=%b res=%h expected 001/5a", rsp_valid, rsp_result);
        end
      end
      cyc();
    end
    checks++;
    if (exp_tag_q.size() != 0) begin
      errors++;
      $display("FAIL rr_leftover: got %0d pending expected 0", exp_tag_q.size());
      exp_tag_q.delete();
    end
  endtask

  task automatic test_grant_lock();
    do_reset();
    req_valid  = 3'b001;
    unit_ready = 1'b1;
    issue_n(1, "lock_pre");          // rr_ptr now 1
    unit_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req_valid = 3'b011;
      #1;
      checks++;
      if (unit_valid !== 1'b1 || unit_tag !== 2'd0 || unit_payload !== req_payload[0] || req_ready !== 3'b000) begin
        errors++;
        $display("FAIL lock_hold[%0d]: got v=%b tag=%0d pl=%h rdy=%b expected 1/0/%h/000",
                 c, unit_valid, unit_tag, unit_payload, req_ready, req_payload[0]);
      end
      cyc();
    end
    unit_ready = 1'b1;
    #1;
    checks++;
    if (unit_tag !== 2'd0 || req_ready !== 3'b001) begin
      errors++;
      $display("FAIL lock_accept: got tag=%0d rdy=%b expected 0/001", unit_tag, req_ready);
    end
    cyc();
    #1;
    checks++;
    if (unit_tag !== 2'd1 || req_ready !== 3'b010) begin
      errors++;
      $display("FAIL lock_next: got tag=%0d rdy=%b expected 1/010", unit_tag, req_ready);
    end
    cyc();
  endtask

  task automatic test_credit_limit();
    do_reset();
    req_valid  = 3'b001;
    unit_ready = 1'b1;
    issue_n(MO, "credit_issue");
    #1;
    checks++;
    if (unit_valid !== 1'b0 || req_ready !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL credit_full: got v=%b rdy=%b busy=%b expected 0/000/1", unit_valid, req_ready, busy);
    end
    cyc();
    res_valid = 1'b1;
    res_tag   = 2'd0;
    rsp_ready = 3'b001;
    #1;
    checks++;
    if (unit_valid !== 1'b1 || req_ready !== 3'b001 || res_ready !== 1'b1 || rsp_valid !== 3'b001) begin
      errors++;
      $display("FAIL credit_retire_issue: got v=%b rdy=%b rr=%b rsp=%b expected 1/001/1/001",
               unit_valid, req_ready, res_ready, rsp_valid);
    end
    cyc();
    res_valid = 1'b0;
    #1;
    checks++;
    if (unit_valid !== 1'b0) begin
      errors++;
      $display("FAIL credit_still_full: got v=%b expected 0", unit_valid);
    end
    cyc();
    req_valid = 3'b000;
    res_valid = 1'b1;
    cyc();
    res_valid = 1'b0;
    req_valid = 3'b001;
    #1;
    checks++;
    if (unit_valid !== 1'b1) begin
      errors++;
      $display("FAIL credit_freed: got v=%b expected 1", unit_valid);
    end
    cyc();
  endtask

  task automatic test_result_routing();
    do_reset();
    res_valid = 1'b1;
    res_tag   = 2'd1;
    res       = 8'hA5;
    rsp_ready = 3'b001;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 3'b010 || res_ready !== 1'b0 || rsp_result !== 8'hA5) begin
        errors++;
        $display("FAIL route_wait[%0d]: got rsp=%b rdy=%b res=%h expected 010/0/a5",
                 c, rsp_valid, res_ready, rsp_result);
      end
      cyc();
    end
    rsp_ready = 3'b010;
    #1;
    checks++;
    if (rsp_valid !== 3'b010 || res_ready !== 1'b1) begin
      errors++;
      $display("FAIL route_accept: got rsp=%b rdy=%b expected 010/1", rsp_valid, res_ready);
    end
    cyc();
    res_tag   = 2'd2;
    res       = 8'h3C;
    rsp_ready = 3'b100;
    #1;
    checks++;
    if (rsp_valid !== 3'b100 || res_ready !== 1'b1 || rsp_result !== 8'h3C) begin
      errors++;
      $display("FAIL route_tag2: got rsp=%b rdy=%b res=%h expected 100/1/3c", rsp_valid, res_ready, rsp_result);
    end
    res_tag   = 2'd0;
    rsp_ready = 3'b110;
    #1;
    checks++;
    if (rsp_valid !== 3'b001 || res_ready !== 1'b0 || tag_err !== 1'b0) begin
      errors++;
      $display("FAIL route_tag0: got rsp=%b rdy=%b te=%b expected 001/0/0", rsp_valid, res_ready, tag_err);
    end
    cyc();
  endtask

  task automatic test_bad_tag();
    do_reset();
    req_valid  = 3'b001;
    unit_ready = 1'b1;
    issue_n(2, "badtag_pre");
    req_valid = 3'b000;
    res_valid = 1'b1;
    res_tag   = 2'd3;
    rsp_ready = 3'b000;
    #1;
    checks++;
    if (res_ready !== 1'b1 || rsp_valid !== 3'b000 || tag_err !== 1'b0) begin
      errors++;
      $display("FAIL badtag_sink: got rdy=%b rsp=%b te=%b expected 1/000/0", res_ready, rsp_valid, tag_err);
    end
    cyc();
    res_valid = 1'b0;
    #1;
    checks++;
    if (tag_err !== 1'b1) begin
      errors++;
      $display("FAIL badtag_pulse: got te=%b expected 1", tag_err);
    end
    cyc();
    req_valid = 3'b001;
    #1;
    checks++;
    if (tag_err !== 1'b0) begin
      errors++;
      $display("FAIL badtag_pulse_end: got te=%b expected 0", tag_err);
    end
    issue_n(3, "badtag_refill");     // counter was 1, three more fill it
    #1;
    checks++;
    if (unit_valid !== 1'b0) begin
      errors++;
      $display("FAIL badtag_cnt: got v=%b expected 0", unit_valid);
    end
    cyc();
  endtask

  task automatic test_flush_reset();
    do_reset();
    req_valid  = 3'b001;
    unit_ready = 1'b1;
    issue_n(3, "flush_pre");
    unit_ready = 1'b0;
    cyc();                            // locked on requester 0, rr_ptr 1
    flush = 1'b1;
    #1;
    checks++;
    if (unit_valid !== 1'b0 || req_ready !== 3'b000 || unit_flush !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_during: got v=%b rdy=%b uf=%b busy=%b expected 0/000/1/1",
               unit_valid, req_ready, unit_flush, busy);
    end
    cyc();
    flush     = 1'b0;
    req_valid = 3'b000;
    #1;
    checks++;
    if (busy !== 1'b0 || unit_flush !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got busy=%b uf=%b expected 0/0", busy, unit_flush);
    end
    req_valid = 3'b011;
    #1;
    checks++;
    if (unit_tag !== 2'd1) begin
      errors++;
      $display("FAIL flush_unlock: got tag=%0d expected 1", unit_tag);
    end
    cyc();

    do_reset();
    req_valid  = 3'b001;
    unit_ready = 1'b1;
    issue_n(2, "arst_pre");
    req_valid = 3'b000;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_busy_before: got %b expected 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || tag_err !== 1'b0) begin
      errors++;
      $display("FAIL arst_async: got busy=%b te=%b expected 0/0", busy, tag_err);
    end
    #1;
    rst = 1'b0;
    cyc();
    res_valid = 1'b1;
    res_tag   = 2'd0;
    rsp_ready = 3'b001;
    cyc();
    res_valid = 1'b0;
    req_valid = 3'b001;
    issue_n(MO, "arst_refill");
    #1;
    checks++;
    if (unit_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_saturate: got v=%b expected 0", unit_valid);
    end
    cyc();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) req_payload[i] = 16'(32'hA000 + i * 32'h0111);
    test_reset();
    test_round_robin();
    test_grant_lock();
    test_credit_limit();
    test_result_routing();
    test_bad_tag();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpnew_opgroup_issue_arb.md
# fpnew_opgroup_issue_arb

Issue controller that shares one operation-group block (for example a single ADDMUL or DIVSQRT block) between `NumReq` independent requesters. It round-robin arbitrates incoming operations onto the block's input handshake and stamps each issued operation with its requester ID as the tag. It limits the number of operations in flight with an outstanding-operation counter and routes each returning result to the owning requester by tag. It sits between the requester front-ends and the opgroup block's `in_*`/`out_*` handshakes.

## Interface
- `NumReq`, default 2: number of requesters, 1..16.
- `PayloadWidth`, default 128: width of the opaque operation bundle (operands, op, formats, rounding mode).
- `ResultWidth`, default 38: width of the opaque result bundle (result, status, extension bit).
- `MaxOutstanding`, default 4: maximum operations in flight, 1..15.
- `IdWidth`, derived: max(1, $clog2(NumReq)).
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `flush_i`  in  1  synchronous flush; discards all in-flight tracking.
- `req_valid_i`  in  NumReq  per-requester operation valid.
- `req_ready_o`  out  NumReq  per-requester operation accepted.
- `req_payload_i`  in  NumReq×PayloadWidth  per-requester operation bundle.
- `unit_valid_o`  out  1  to the block's `in_valid_i`.
- `unit_ready_i`  in  1  from the block's `in_ready_o`.
- `unit_payload_o`  out  PayloadWidth  granted bundle.
- `unit_tag_o`  out  IdWidth  granted requester ID.
- `unit_flush_o`  out  1  equals `flush_i`.
- `unit_res_valid_i`  in  1  from the block's `out_valid_o`.
- `unit_res_ready_o`  out  1  to the block's `out_ready_i`.
- `unit_res_tag_i`  in  IdWidth  tag of the returning result.
- `unit_res_i`  in  ResultWidth  returning result bundle.
- `rsp_valid_o`  out  NumReq  per-requester result valid.
- `rsp_ready_i`  in  NumReq  per-requester result ready.
- `rsp_result_o`  out  ResultWidth  `unit_res_i`, broadcast to all requesters.
- `tag_err_o`  out  1  one-cycle pulse when a result with tag ≥ NumReq is sunk.
- `busy_o`  out  1  high when the outstanding count is nonzero or `unit_valid_o` is high.

## Operation
- **Registered state**
  - `rr_ptr` [IdWidth]: round-robin priority pointer.
  - `lock` plus `lock_id`: grant hold.
  - `cnt` [0..MaxOutstanding]: outstanding count.
  - `tag_err_q`: registers the tag-error pulse.
- **Arbitration**
  - The grant goes to the first requester with `req_valid_i` set, searching from `rr_ptr` upward and wrapping.
  - When `lock` is set, the grant is `lock_id` regardless of other requests.
- **Credit gate**
  - `can_issue` = `cnt < MaxOutstanding`, OR a result handshake happens in the same cycle (a same-cycle retire frees a slot).
- **Issue path**
  - `unit_valid_o` = any request valid AND `can_issue`.
  - `unit_payload_o` and `unit_tag_o` come from the granted requester.
  - `req_ready_o[g]` = `unit_valid_o & unit_ready_i`; it is 0 for all non-granted requesters.
- **Grant states**
  - State FREE (`lock`=0): if `unit_valid_o` is high and `unit_ready_i` is low, go to LOCKED with `lock_id` = the granted ID.
  - State LOCKED: stay until `unit_ready_i` is high, then return to FREE.
  - This keeps payload and tag stable while valid is held (AXI-style: valid never drops before ready).
- **Pointer update**
  - On each issue handshake, `rr_ptr` becomes grant+1, wrapping from NumReq-1 to 0.
- **Result routing**
  - Valid tag: `rsp_valid_o[t]` = `unit_res_valid_i`, all other bits 0, and `unit_res_ready_o` = `rsp_ready_i[t]`.
  - Tag t ≥ NumReq: `unit_res_ready_o`=1, the result is dropped, and `tag_err_o` pulses in the next cycle.
  - A dropped result still decrements `cnt`.
- **Counter**
  - `cnt` += issue handshake, −= result handshake; simultaneous issue and retire leave it unchanged.
  - A result handshake at `cnt`=0 is ignored and `cnt` saturates at 0.
- **Flush**
  - `cnt`←0, `lock`←0, `rr_ptr` unchanged, `tag_err_q`←0.
  - While `flush_i` is high, `unit_valid_o`=0 and `req_ready_o`=0.

## Timing
- Issue is combinational: a request, arbitration and `unit_valid_o` occur in the same cycle with zero added latency.
- Result routing is combinational.
- Reset values:
  - `rr_ptr`=0, `lock`=0, `cnt`=0, `tag_err_q`=0.
  - All outputs 0 while no inputs are asserted; `busy_o`=0.
- Reset asserted mid-operation clears all state immediately (asynchronous reset). In-flight results arriving afterwards do not decrement below 0.
- Priority: `flush_i` overrides issue and counter updates in the same cycle.
- Back-to-back issues are allowed every cycle while `cnt < MaxOutstanding`.
- With `cnt`=MaxOutstanding, issue resumes in the same cycle as a retire.

## Test plan
- **Round robin:** NumReq=2, both requesters valid continuously, `unit_ready_i`=1, results returned each cycle. Grants alternate 0,1,0,1 and `unit_tag_o` follows.
- **Grant lock:** Requester 0 valid with `unit_ready_i`=0 for 3 cycles; requester 1 raises valid in cycle 2. Payload and tag stay on ID 0 until ready, then requester 1 is granted next.
- **Credit limit:** MaxOutstanding=4, no results returned. Exactly 4 issues, then `unit_valid_o`=0. A result in cycle 6 together with a pending request gives an issue in cycle 6 and `cnt` stays 4.
- **Result routing:** Result with tag 1 while `rsp_ready_i`=2'b01. `rsp_valid_o`=2'b10, `unit_res_ready_o`=0 until `rsp_ready_i[1]`=1.
- **Bad tag:** NumReq=3 with a result tagged 3. `unit_res_ready_o`=1, `tag_err_o` pulses one cycle later, `cnt` decrements.
- **Flush/reset:** `cnt`=3 with LOCKED state, then pulse `flush_i`. Next cycle `cnt`=0, lock cleared, `busy_o`=0. Asserting `rst_i` asynchronously mid-cycle zeroes state without waiting for a clock edge.
